// File: rtl/rggen_rtl_pkg.sv
// Shared types and constants for the rggen register-block RTL slice:
// response status codes, the host arbiter state encoding and a width helper.
package rggen_rtl_pkg;

    typedef logic [1:0] status_t;

    localparam status_t OKAY        = 2'b00;
    localparam status_t EXOKAY      = 2'b01;
    localparam status_t SLAVE_ERROR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbiter_state_t;

    // Index width for a vector of 'value' entries, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/rggen_host_arbiter_if.sv
// Signal bundle of rggen_host_arbiter: per-host command channels on one side,
// the shared register-block command/response bus on the other.
interface rggen_host_arbiter_if #(
    parameter int unsigned HOSTS         = 2,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 7
);
    localparam int unsigned STROBE_WIDTH = DATA_WIDTH / 8;

    logic [HOSTS-1:0]                    i_command_valid;
    logic [HOSTS-1:0]                    i_write;
    logic [HOSTS-1:0]                    i_read;
    logic [HOSTS-1:0][ADDRESS_WIDTH-1:0] i_address;
    logic [HOSTS-1:0][STROBE_WIDTH-1:0]  i_strobe;
    logic [HOSTS-1:0][DATA_WIDTH-1:0]    i_write_data;
    logic [HOSTS-1:0][DATA_WIDTH-1:0]    i_write_mask;
    logic [HOSTS-1:0]                    o_response_ready;
    logic [DATA_WIDTH-1:0]               o_read_data;
    logic [1:0]                          o_status;

    logic                                o_command_valid;
    logic                                o_write;
    logic                                o_read;
    logic [ADDRESS_WIDTH-1:0]            o_address;
    logic [STROBE_WIDTH-1:0]             o_strobe;
    logic [DATA_WIDTH-1:0]               o_write_data;
    logic [DATA_WIDTH-1:0]               o_write_mask;
    logic                                i_response_ready;
    logic [DATA_WIDTH-1:0]               i_read_data;
    logic [1:0]                          i_status;

    logic [HOSTS-1:0]                    o_grant;

    // Arbiter view: owns every o_* signal.
    modport master (
        input  i_command_valid, i_write, i_read, i_address, i_strobe,
               i_write_data, i_write_mask,
        input  i_response_ready, i_read_data, i_status,
        output o_response_ready, o_read_data, o_status,
        output o_command_valid, o_write, o_read, o_address, o_strobe,
               o_write_data, o_write_mask,
        output o_grant
    );

    // Environment view: hosts plus register block.
    modport slave (
        output i_command_valid, i_write, i_read, i_address, i_strobe,
               i_write_data, i_write_mask,
        output i_response_ready, i_read_data, i_status,
        input  o_response_ready, o_read_data, o_status,
        input  o_command_valid, o_write, o_read, o_address, o_strobe,
               o_write_data, o_write_mask,
        input  o_grant
    );

endinterface

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin pick: first requester at or above the pointer,
// wrapping, plus the pointer value that follows a given one-hot owner.
module rggen_round_robin_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned HOSTS         = 2,
    parameter int unsigned POINTER_WIDTH = clog2_min1(HOSTS)
)(
    input  logic [HOSTS-1:0]         request,
    input  logic [POINTER_WIDTH-1:0] pointer,
    input  logic [HOSTS-1:0]         owner,
    output logic [HOSTS-1:0]         grant,
    output logic [POINTER_WIDTH-1:0] next_pointer
);

    logic [HOSTS-1:0] rotated_request;
    logic [HOSTS-1:0] rotated_grant;

    // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rotated_request = HOSTS'({request, request} >> pointer);
        rotated_grant   = rotated_request & (~rotated_request + HOSTS'(1));
        grant           = HOSTS'(({rotated_grant, rotated_grant} << pointer) >> HOSTS);
    end

    always_comb begin
        next_pointer = '0;
        for (int i = 0; i < HOSTS; i++) begin
            if (owner[i]) begin
                next_pointer = POINTER_WIDTH'((i + 1) % HOSTS);
            end
        end
    end

endmodule

// File: rtl/rggen_host_arbiter.sv
// Non-preemptive round-robin arbiter sharing one register-block command bus among HOSTS hosts.
// Build option RGGEN_HOST_ARBITER_TIMEOUT_EN adds a BUSY watchdog that ends a stalled transaction with SLAVE_ERROR.
module rggen_host_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned HOSTS          = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_WIDTH  = 7,
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic                 clk,
    input  logic                 rst_n,
    rggen_host_arbiter_if.master bus
);

    localparam int unsigned POINTER_WIDTH = clog2_min1(HOSTS);
    localparam int unsigned STROBE_WIDTH  = DATA_WIDTH / 8;

    typedef struct packed {
        logic                     write;
        logic                     read;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [STROBE_WIDTH-1:0]  strobe;
        logic [DATA_WIDTH-1:0]    write_data;
        logic [DATA_WIDTH-1:0]    write_mask;
    } command_t;

    arbiter_state_t           state_q, state_d;
    logic [POINTER_WIDTH-1:0] pointer_q, pointer_d, next_pointer;
    logic [HOSTS-1:0]         grant_q, grant_d, pick;
    command_t                 command_q, command_d, picked_command;
    logic                     busy;
    logic                     response;
    logic                     timeout;

    rggen_round_robin_arbiter #(
        .HOSTS         (HOSTS),
        .POINTER_WIDTH (POINTER_WIDTH)
    ) u_round_robin (
        .request      (bus.i_command_valid),
        .pointer      (pointer_q),
        .owner        (grant_q),
        .grant        (pick),
        .next_pointer (next_pointer)
    );

    // pick is one-hot or zero, so a plain priority loop acts as the host mux.
    always_comb begin
        picked_command = '0;
        for (int i = 0; i < HOSTS; i++) begin
            if (pick[i]) begin
                picked_command.write      = bus.i_write[i];
                picked_command.read       = bus.i_read[i];
                picked_command.address    = bus.i_address[i];
                picked_command.strobe     = bus.i_strobe[i];
                picked_command.write_data = bus.i_write_data[i];
                picked_command.write_mask = bus.i_write_mask[i];
            end
        end
    end

    assign busy = (state_q == BUSY);

`ifdef RGGEN_HOST_ARBITER_TIMEOUT_EN
    localparam int unsigned COUNT_WIDTH = clog2_min1(TIMEOUT_CYCLES);

    logic [COUNT_WIDTH-1:0] busy_count_q;

    // Counts BUSY cycles from 0; the TIMEOUT_CYCLES-th BUSY cycle completes the transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_count_q <= '0;
        end else if (!busy) begin
            busy_count_q <= '0;
        end else begin
            busy_count_q <= busy_count_q + COUNT_WIDTH'(1);
        end
    end

    assign timeout = busy && (busy_count_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign response = busy && (bus.i_response_ready || timeout);

    always_comb begin
        // NOTE: every target gets its hold value first, so no path infers a latch.
        state_d   = state_q;
        pointer_d = pointer_q;
        grant_d   = grant_q;
        command_d = command_q;
        case (state_q)
            IDLE: begin
                if (|bus.i_command_valid) begin
                    state_d   = BUSY;
                    grant_d   = pick;
                    command_d = picked_command;
                end
            end
            BUSY: begin
                if (response) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    pointer_d = next_pointer;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pointer_q <= '0;
            grant_q   <= '0;
            command_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q   <= state_d;
            pointer_q <= pointer_d;
            grant_q   <= grant_d;
            command_q <= command_d;
        end
    end

    assign bus.o_command_valid = busy;
    assign bus.o_grant         = grant_q;
    assign bus.o_write         = command_q.write;
    assign bus.o_read          = command_q.read;
    assign bus.o_address       = command_q.address;
    assign bus.o_strobe        = command_q.strobe;
    assign bus.o_write_data    = command_q.write_data;
    assign bus.o_write_mask    = command_q.write_mask;

    // A real completion wins over the watchdog; nothing leaks out while idle.
    assign bus.o_response_ready = response ? grant_q : '0;
    assign bus.o_read_data      = (busy && bus.i_response_ready) ? bus.i_read_data : '0;

    always_comb begin
        bus.o_status = OKAY;
        if (busy && bus.i_response_ready) begin
            bus.o_status = bus.i_status;
        end else if (timeout) begin
            bus.o_status = SLAVE_ERROR;
        end
    end

endmodule
